// File: rtl/stereo_pkg.sv
// Shared constants and FSM encoding for the stereo
// right-image row pair buffer.
package stereo_pkg;

  localparam int PIXEL_WIDTH = 11;
  localparam int IMG_WIDTH   = 640;
  localparam int IMG_HEIGHT  = 480;
  localparam int COL_W       = 10;
  localparam int ROW_W       = 9;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    FIRST_ROW = 2'd1,
    STREAM    = 2'd2
  } state_t;

endpackage

// File: rtl/row_ram.sv
// Single-port row store, read-before-write, with a
// registered read port that holds when not enabled.
module row_ram #(
  parameter int DEPTH = 640,
  parameter int WIDTH = 11,
  parameter int AW    = 10
) (
  input  logic             clock,
  input  logic             rst,
  input  logic             en,
  input  logic [AW-1:0]    addr,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  // storage itself is never reset so it maps onto block RAM
  always_ff @(posedge clock) begin
    if (en) mem[addr] <= wdata;
  end

  always_ff @(posedge clock or negedge rst) begin
    if (!rst) begin
      rdata <= '0;
    end else if (en) begin
      rdata <= mem[addr];
    end
  end

endmodule

// File: rtl/stereo_row_pair_buffer.sv
// Row pair buffer: pairs each incoming pixel with the
// pixel one row above it and qualifies the pair with clken.
module stereo_row_pair_buffer #(
  parameter int PIXEL_WIDTH = stereo_pkg::PIXEL_WIDTH,
  parameter int IMG_WIDTH   = stereo_pkg::IMG_WIDTH,
  parameter int IMG_HEIGHT  = stereo_pkg::IMG_HEIGHT,
  parameter int COL_W       = stereo_pkg::COL_W,
  parameter int ROW_W       = stereo_pkg::ROW_W
) (
  input  logic                   clock,
  input  logic                   rst,
  input  logic [PIXEL_WIDTH-1:0] pixel_in,
  input  logic                   pixel_valid,
  input  logic                   sof,
  output logic [PIXEL_WIDTH-1:0] linebuffer0,
  output logic [PIXEL_WIDTH-1:0] linebuffer1,
  output logic                   clken,
  output logic                   row_first,
  output logic                   frame_done,
  output logic                   busy
);

  import stereo_pkg::state_t;
  import stereo_pkg::IDLE;
  import stereo_pkg::FIRST_ROW;
  import stereo_pkg::STREAM;

  state_t           state, state_nxt;
  logic [COL_W-1:0] col, col_nxt, addr;
  logic [ROW_W-1:0] row, row_nxt;
  logic             accept, take_sof, step;
  logic             end_col, end_frame, beat;

  always_comb begin
    take_sof  = pixel_valid && sof;
    accept    = pixel_valid && (state != IDLE || sof);
    step      = accept && !sof;
    end_col   = (col == COL_W'(IMG_WIDTH - 1));
    end_frame = end_col && (row == ROW_W'(IMG_HEIGHT - 1));
    beat      = step && (state == STREAM);
    // a sof pixel is always (0,0), whatever col says
    addr      = take_sof ? '0 : col;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (take_sof) state_nxt = FIRST_ROW;
      end
      FIRST_ROW: begin
        if (take_sof)
          state_nxt = FIRST_ROW;
        else if (step && end_col)
          state_nxt = STREAM;
      end
      STREAM: begin
        if (take_sof)
          state_nxt = FIRST_ROW;
        else if (step && end_frame)
          state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    col_nxt = col;
    row_nxt = row;
    unique case (1'b1)
      take_sof: begin
        col_nxt = COL_W'(1);
        row_nxt = '0;
      end
      step && end_col: begin
        col_nxt = '0;
        row_nxt = end_frame ? '0 : row + 1'b1;
      end
      step && !end_col: begin
        col_nxt = col + 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      col         <= '0;
      row         <= '0;
      linebuffer0 <= '0;
      clken       <= 1'b0;
      row_first   <= 1'b0;
      frame_done  <= 1'b0;
    end else begin
      state       <= state_nxt;
      col         <= col_nxt;
      row         <= row_nxt;
      clken       <= beat;
      row_first   <= beat && (col == '0);
      frame_done  <= beat && end_frame;
      if (accept) linebuffer0 <= pixel_in;
    end
  end

  assign busy = (state != IDLE);

  row_ram #(
    .DEPTH (IMG_WIDTH),
    .WIDTH (PIXEL_WIDTH),
    .AW    (COL_W)
  ) u_ram (
    .clock (clock),
    .rst   (rst),
    .en    (accept),
    .addr  (addr),
    .wdata (pixel_in),
    .rdata (linebuffer1)
  );

endmodule

// File: tb/tb_stereo_row_pair_buffer.sv
// Randomised bench for stereo_row_pair_buffer on an 8x4
// frame, checked against a frame-index reference model.
module tb_stereo_row_pair_buffer;

  localparam int PW = 11;
  localparam int W  = 8;
  localparam int H  = 4;
  localparam int N  = W * H;

  logic          clock = 1'b0;
  logic          rst = 1'b0;
  logic          pixel_valid = 1'b0;
  logic          sof = 1'b0;
  logic [PW-1:0] pixel_in = '0;
  logic [PW-1:0] linebuffer0, linebuffer1;
  logic          clken, row_first, frame_done, busy;

  always #5 clock = ~clock;

  stereo_row_pair_buffer #(
    .PIXEL_WIDTH (PW),
    .IMG_WIDTH   (W),
    .IMG_HEIGHT  (H),
    .COL_W       (3),
    .ROW_W       (2)
  ) dut (
    .clock       (clock),
    .rst         (rst),
    .pixel_in    (pixel_in),
    .pixel_valid (pixel_valid),
    .sof         (sof),
    .linebuffer0 (linebuffer0),
    .linebuffer1 (linebuffer1),
    .clken       (clken),
    .row_first   (row_first),
    .frame_done  (frame_done),
    .busy        (busy)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // reference model: position inside the frame and the row store
  int            idx = -1;
  logic [PW-1:0] mem [W];
  bit            known [W];
  logic [PW-1:0] e_lb0 = '0, e_lb1 = '0;
  bit            k0 = 1'b1, k1 = 1'b1;
  int            beats = 0, dones = 0;

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d",
               tag, obs, exp);
    end
  endtask

  task automatic step(input logic v, input logic s,
                      input logic [PW-1:0] p);
    bit acc, e_clk, e_rf, e_fd;
    int pos, c;
    pixel_valid = v;
    sof         = s;
    pixel_in    = p;
    @(posedge clock);
    #1;
    acc   = v && (s || idx >= 0);
    e_clk = 1'b0;
    e_rf  = 1'b0;
    e_fd  = 1'b0;
    if (acc) begin
      pos   = s ? 0 : idx;
      c     = pos % W;
      e_clk = !s && pos >= W;
      e_rf  = e_clk && c == 0;
      e_fd  = e_clk && pos == N - 1;
      e_lb0 = p;
      e_lb1 = mem[c];
      k0    = 1'b1;
      k1    = known[c];
      mem[c]   = p;
      known[c] = 1'b1;
      idx = (pos == N - 1) ? -1 : pos + 1;
    end
    check("clken", clken, e_clk);
    check("row_first", row_first, e_rf);
    check("frame_done", frame_done, e_fd);
    check("busy", busy, idx >= 0);
    if (k0) check("lb0", linebuffer0, e_lb0);
    if (k1) check("lb1", linebuffer1, e_lb1);
    if (clken === 1'b1) beats++;
    if (frame_done === 1'b1) dones++;
  endtask

  task automatic reset_now();
    rst         = 1'b0;
    pixel_valid = 1'b0;
    sof         = 1'b0;
    #1;
    idx   = -1;
    e_lb0 = '0;
    e_lb1 = '0;
    k0    = 1'b1;
    k1    = 1'b1;
    check("rst_clken", clken, 0);
    check("rst_rf", row_first, 0);
    check("rst_fd", frame_done, 0);
    check("rst_busy", busy, 0);
    check("rst_lb0", linebuffer0, 0);
    check("rst_lb1", linebuffer1, 0);
    @(posedge clock);
    #1;
    rst = 1'b1;
  endtask

  // gap: 0 none, 1 one idle cycle per pixel, 2 random idles
  task automatic run_frame(input int gap, input bit rnd,
                           input int stop_at);
    logic [PW-1:0] p;
    for (int i = 0; i < stop_at; i++) begin
      if (gap == 1) begin
        step(1'b0, 1'($urandom % 2), PW'($urandom));
      end else if (gap == 2) begin
        for (int g = $urandom % 3; g > 0; g--)
          step(1'b0, 1'($urandom % 2), PW'($urandom));
      end
      if (rnd) p = PW'($urandom);
      else     p = PW'((i / W) * 16 + (i % W));
      step(1'b1, i == 0, p);
    end
  endtask

  task automatic tally(input string tag,
                       input int nb, input int nd);
    check({tag, "_beats"}, beats, nb);
    check({tag, "_dones"}, dones, nd);
    beats = 0;
    dones = 0;
  endtask

  initial begin
    for (int i = 0; i < W; i++) known[i] = 1'b0;
    reset_now();

    run_frame(0, 1'b0, N);
    step(1'b0, 1'b0, '0);
    tally("plain", (H - 1) * W, 1);

    run_frame(1, 1'b0, N);
    step(1'b0, 1'b0, '0);
    tally("toggle", (H - 1) * W, 1);

    for (int i = 0; i < 5; i++)
      step(1'b1, 1'b0, PW'($urandom));
    tally("idle_nosof", 0, 0);

    run_frame(0, 1'b1, 2 * W + 3);
    run_frame(0, 1'b1, N);
    step(1'b0, 1'b0, '0);
    tally("abort", W + 3 + (H - 1) * W, 1);

    run_frame(0, 1'b1, N);
    run_frame(0, 1'b1, N);
    step(1'b0, 1'b0, '0);
    tally("b2b", 2 * (H - 1) * W, 2);

    run_frame(0, 1'b0, 2 * W + 2);
    #2;
    reset_now();
    beats = 0;
    dones = 0;
    run_frame(0, 1'b0, N);
    step(1'b0, 1'b0, '0);
    tally("post_rst", (H - 1) * W, 1);

    for (int f = 0; f < 4; f++) begin
      run_frame(2, 1'b1, N);
    end
    step(1'b0, 1'b0, '0);
    tally("random", 4 * (H - 1) * W, 4);

    $display("[TB] %0d tests run, %0d failed",
             n_tests, n_fail);
    $finish;
  end

endmodule
